// File: rtl/bram_portb_arbiter_if.sv
// bram_portb_arbiter_if: VGA read, PS2 status and BRAM port-B signals shared by the arbiter and its environment
interface bram_portb_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int PS2_W  = 6
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic [PS2_W-1:0]  ps2_status;
  logic              ps2_busy;
  logic [ADDR_W-1:0] bport_addr;
  logic              bport_we;
  logic [DATA_W-1:0] bport_data;
  logic [DATA_W-1:0] bport_q;
  modport slave (
    input  vga_req, vga_addr, ps2_status, bport_q,
    output vga_gnt, vga_rdata, vga_rvalid, ps2_busy, bport_addr, bport_we, bport_data
  );
  modport master (
    output vga_req, vga_addr, ps2_status, bport_q,
    input  vga_gnt, vga_rdata, vga_rvalid, ps2_busy, bport_addr, bport_we, bport_data
  );
endinterface

// File: rtl/bram_portb_arbiter.sv
// bram_portb_arbiter: shares BRAM port B between VGA reads (priority) and PS2 mailbox writes with bounded deferral
module bram_portb_arbiter #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter int                PS2_W     = 6,
  parameter logic [ADDR_W-1:0] PS2_ADDR  = 10'h3FF,
  parameter int                MAX_DEFER = 8
) (
  input logic clk,
  input logic rst,
  bram_portb_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_DEFER + 1);
  typedef enum logic [1:0] {IDLE, VGA, PS2WR} state_t;
  state_t            state_q, state_d;
  logic              pending_q, pending_d, rd_inflight_q, rd_inflight_d, rvalid_q, rvalid_d;
  logic [PS2_W-1:0]  snap_q, snap_d, last_q, last_d;
  logic [CW-1:0]     defer_q, defer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr, chg, pend_now, defer_full;
  // During a write cycle the snapshot is compared instead of last_written, so a same-cycle change re-arms at once
  always_comb begin
    wr            = state_q == PS2WR;
    chg           = bus.ps2_status != (wr ? snap_q : last_q);
    pending_d     = chg || (pending_q && !wr);
    snap_d        = pending_d ? bus.ps2_status : snap_q;
    last_d        = wr ? snap_q : last_q;
    pend_now      = wr ? pending_d : pending_q;
    defer_full    = !wr && defer_q == CW'(MAX_DEFER);
    state_d       = (pend_now && (!bus.vga_req || defer_full)) ? PS2WR : bus.vga_req ? VGA : IDLE;
    defer_d       = wr ? '0 : state_q != VGA ? defer_q : !pending_q ? '0 :
                    defer_full ? defer_q : defer_q + CW'(1);
    addr_d        = state_d == VGA ? bus.vga_addr : state_d == PS2WR ? PS2_ADDR : addr_q;
    rd_inflight_d = state_q == VGA;
    rvalid_d      = rd_inflight_q;
    rdata_d       = rd_inflight_q ? bus.bport_q : rdata_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      snap_q        <= '0;
      last_q        <= '0;
      defer_q       <= '0;
      addr_q        <= '0;
      rd_inflight_q <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      snap_q        <= snap_d;
      last_q        <= last_d;
      defer_q       <= defer_d;
      addr_q        <= addr_d;
      rd_inflight_q <= rd_inflight_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  assign bus.vga_gnt    = state_q == VGA;
  assign bus.bport_we   = wr;
  assign bus.bport_addr = addr_q;
  assign bus.bport_data = wr ? DATA_W'(snap_q) : '0;
  assign bus.vga_rdata  = rdata_q;
  assign bus.vga_rvalid = rvalid_q;
  assign bus.ps2_busy   = pending_q;
endmodule

// File: tb/tb_bram_portb_arbiter.sv
// tb_bram_portb_arbiter: directed steps with a read-data scoreboard and a BRAM model behind port B
module tb_bram_portb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bram_portb_arbiter_if bif();
  bram_portb_arbiter dut (.clk(clk), .rst(rst), .bus(bif));
  logic [15:0] exp_q[$];
  logic [15:0] mbox = '0;
  logic [15:0] mb_mem = '0;
  logic [15:0] last_wr = '0;
  int checks = 0, failures = 0, rv_cnt = 0, wr_cnt = 0;
  always @(posedge clk) begin
    if (bif.bport_we && bif.bport_addr == 10'h3FF) mb_mem <= bif.bport_data;
    bif.bport_q <= bif.bport_addr == 10'h3FF ? mb_mem : 16'(int'(bif.bport_addr) * 3);
  end
  function automatic logic [15:0] exp_word(input logic [9:0] a);
    return a == 10'h3FF ? mbox : 16'(int'(a) * 3);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, bif.vga_gnt, 0);
    chk({tag, "_rvalid"}, bif.vga_rvalid, 0);
    chk({tag, "_rdata"}, bif.vga_rdata, 0);
    chk({tag, "_busy"}, bif.ps2_busy, 0);
    chk({tag, "_addr"}, bif.bport_addr, 0);
    chk({tag, "_we"}, bif.bport_we, 0);
    chk({tag, "_data"}, bif.bport_data, 0);
  endtask
  // A grant seen after the edge belongs to the address driven before that edge
  task automatic step(input logic req, input logic [9:0] a, input logic [5:0] st);
    bif.vga_req = req;
    bif.vga_addr = a;
    bif.ps2_status = st;
    @(negedge clk);
    #1;
    if (bif.vga_gnt === 1'b1) exp_q.push_back(exp_word(a));
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bif.vga_rvalid === 1'b1) begin
        rv_cnt++;
        if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
        else chk("rdata", bif.vga_rdata, exp_q.pop_front());
      end
      if (bif.bport_we === 1'b1) begin
        wr_cnt++;
        last_wr = bif.bport_data;
        chk("we_excl_gnt", bif.vga_gnt, 0);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [9:0] a;
    int n, rv0, wc0, deferred;
    logic prev, got;
    bif.vga_req = 1'b0;
    bif.vga_addr = '0;
    bif.ps2_status = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("idle_busy", bif.ps2_busy, 0);
    chk("idle_we", bif.bport_we, 0);
    a = 0;
    n = 0;
    rv0 = rv_cnt;
    while (a < 16 && n < 40) begin
      step(1, a, 0);
      n++;
      if (n == 1) chk("lat_gnt", bif.vga_gnt, 1);
      if (n == 2) chk("lat_rv_early", bif.vga_rvalid, 0);
      if (n == 3) chk("lat_rv_3cyc", bif.vga_rvalid, 1);
      if (bif.vga_gnt) a++;
    end
    chk("stream_cycles", n, 16);
    repeat (3) step(0, 0, 0);
    chk("stream_rv_cnt", rv_cnt - rv0, 16);
    chk("stream_last", bif.vga_rdata, 45);
    for (int i = 4; i < 7; i++) step(1, 10'(i), 6'h2A);
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    exp_q.delete();
    step(1, 7, 6'h2A);
    step(0, 0, 6'h2A);
    rst = 1'b0;
    rv0 = rv_cnt;
    step(0, 0, 6'h2A);
    chk("rst_redetect_busy", bif.ps2_busy, 1);
    step(0, 0, 6'h2A);
    chk("rst_redetect_we", bif.bport_we, 1);
    chk("rst_redetect_data", bif.bport_data, 16'h002A);
    mbox = 16'h002A;
    step(0, 0, 6'h2A);
    chk("rst_no_rvalid", rv_cnt - rv0, 0);
    step(0, 0, 6'h21);
    chk("idle_wr_busy", bif.ps2_busy, 1);
    step(0, 0, 6'h21);
    chk("idle_wr_we", bif.bport_we, 1);
    chk("idle_wr_addr", bif.bport_addr, 10'h3FF);
    chk("idle_wr_data", bif.bport_data, 16'h0021);
    mbox = 16'h0021;
    step(0, 0, 6'h21);
    chk("idle_wr_done", bif.ps2_busy, 0);
    step(1, 5, 6'h21);
    step(1, 5, 6'h21);
    deferred = 0;
    prev = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1, 5, 6'h05);
      if (bif.bport_we) begin
        got = 1'b1;
        chk("starve_gnt_off", bif.vga_gnt, 0);
        chk("starve_data", bif.bport_data, 16'h0005);
      end else if (bif.vga_gnt && prev) deferred++;
      prev = bif.ps2_busy;
    end
    chk("starve_wr_seen", got, 1);
    chk("starve_deferred", deferred, 8);
    mbox = 16'h0005;
    step(1, 5, 6'h05);
    chk("starve_resume_gnt", bif.vga_gnt, 1);
    chk("starve_resume_busy", bif.ps2_busy, 0);
    wc0 = wr_cnt;
    step(1, 7, 6'h01);
    step(1, 7, 6'h02);
    step(1, 7, 6'h04);
    repeat (12) step(1, 7, 6'h04);
    chk("coal_wr_cnt", wr_cnt - wc0, 1);
    chk("coal_data", last_wr, 16'h0004);
    chk("coal_busy", bif.ps2_busy, 0);
    mbox = 16'h0004;
    n = 0;
    do begin
      step(1, 10'h3FF, 6'h04);
      n++;
    end while (!bif.vga_gnt && n < 20);
    chk("coal_rb_gnt", bif.vga_gnt, 1);
    repeat (3) step(0, 0, 6'h04);
    chk("coal_readback", bif.vga_rdata, 16'h0004);
    wc0 = wr_cnt;
    step(0, 0, 6'h30);
    chk("coll_busy0", bif.ps2_busy, 1);
    step(0, 0, 6'h30);
    chk("coll_we1", bif.bport_we, 1);
    chk("coll_data1", bif.bport_data, 16'h0030);
    step(0, 0, 6'h31);
    chk("coll_we2", bif.bport_we, 1);
    chk("coll_data2", bif.bport_data, 16'h0031);
    chk("coll_busy_between", bif.ps2_busy, 1);
    step(0, 0, 6'h31);
    chk("coll_done_busy", bif.ps2_busy, 0);
    chk("coll_done_we", bif.bport_we, 0);
    chk("coll_wr_cnt", wr_cnt - wc0, 2);
    repeat (3) step(0, 0, 6'h31);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
